// File: rtl/sampled_value_seq.sv
// Stimulus sequencer and golden reference for $changed/$stable/$rose/$fell checks.
// Optional SVF_SEQ_SELFCHECK_EN adds obs_changed/mismatch/mismatch_cnt for monitor comparison.
module sampled_value_seq #(
    parameter int MAX_CYC = 11,
    parameter int WIDTH   = 1,
    parameter int CYC_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [3:0]       period,
    output logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] past_val,
    output logic             changed,
    output logic             stable,
    output logic             rose,
    output logic             fell,
    output logic [CYC_W-1:0] cyc,
    output logic             busy,
    output logic             done
`ifdef SVF_SEQ_SELFCHECK_EN
    ,
    input  logic             obs_changed,
    output logic             mismatch,
    output logic [7:0]       mismatch_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0]       MODE_HOLD  = 2'd1;
    localparam logic [1:0]       MODE_PULSE = 2'd2;
    localparam logic [1:0]       MODE_INC   = 2'd3;
    localparam logic [CYC_W-1:0] LAST_CYC   = CYC_W'(MAX_CYC - 1);

    state_t      state;
    logic [1:0]  mode_q;
    logic [3:0]  period_q;
    logic [3:0]  div;
    logic        valid;
    logic        accept;

    // Pulse mode's first step is a plain toggle; its hold counting happens only in RUN.
    function automatic logic [WIDTH-1:0] next_val(input logic [1:0] m, input logic [WIDTH-1:0] v);
        case (m)
            MODE_HOLD: return v;
            MODE_INC:  return v + WIDTH'(1);
            default:   return ~v;
        endcase
    endfunction

    assign accept = (state == IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            val      <= '0;
            past_val <= '0;
            cyc      <= '0;
            div      <= '0;
            mode_q   <= '0;
            period_q <= '0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        mode_q   <= mode;
                        period_q <= period;
                        past_val <= val;
                        val      <= next_val(mode, val);
                        cyc      <= '0;
                        div      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        past_val <= val;
                        if (mode_q == MODE_PULSE) begin
                            if (div == period_q) begin
                                val <= ~val;
                                div <= '0;
                            end else begin
                                div <= div + 4'd1;
                            end
                        end else begin
                            val <= next_val(mode_q, val);
                        end
                        if (cyc == LAST_CYC) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            cyc <= cyc + CYC_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign valid   = (state == RUN);
    assign busy    = valid;
    assign changed = valid && (val != past_val);
    assign stable  = valid && (val == past_val);
    assign rose    = valid && val[0] && !past_val[0];
    assign fell    = valid && !val[0] && past_val[0];

`ifdef SVF_SEQ_SELFCHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            mismatch <= 1'b0;
            if (accept) begin
                mismatch_cnt <= '0;
            end else if (valid && (obs_changed != changed)) begin
                mismatch <= 1'b1;
                if (mismatch_cnt != 8'hFF)
                    mismatch_cnt <= mismatch_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sampled_value_seq.sv
// Bench for sampled_value_seq: two configurations (11 cycles x 1 bit, 6 cycles x 2 bits) on shared stimulus.
// Model predicts val from the count of updates since start; literal expectations pin each test.
module tb_sampled_value_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] period = 4'd0;

    logic [0:0] val0, past0;
    logic [1:0] val1, past1;
    logic       chg0, stb0, rose0, fell0, busy0, done0;
    logic       chg1, stb1, rose1, fell1, busy1, done1;
    logic [7:0] cyc0, cyc1;
`ifdef SVF_SEQ_SELFCHECK_EN
    logic       obs0 = 1'b0, obs1 = 1'b0;
    logic       mm0, mm1;
    logic [7:0] mcnt0, mcnt1;
    int         m_mm[2];
    int         m_cnt[2];
    bit         flip_en = 1'b0;
    int         mm_pulses0;
`endif

    int n_run = 0;
    int n_fail = 0;

    // model state: 0 idle, 1 run, 2 done
    int m_st[2], m_n[2], m_v0[2], m_mode[2], m_per[2], m_cyc[2];

    // literal statistics gathered from the DUT
    int s, cnt_chg0, cnt_stb0, cnt_rose0, cnt_fell0, cnt_done0, done_step0, chg_mask0;
    int cnt_chg1, done_step1, trace1;
    bit rose_first0;

    always #5 clk = ~clk;

    sampled_value_seq #(.MAX_CYC(11), .WIDTH(1), .CYC_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .period(period),
        .val(val0), .past_val(past0), .changed(chg0), .stable(stb0), .rose(rose0), .fell(fell0),
        .cyc(cyc0), .busy(busy0), .done(done0)
`ifdef SVF_SEQ_SELFCHECK_EN
        , .obs_changed(obs0), .mismatch(mm0), .mismatch_cnt(mcnt0)
`endif
    );

    sampled_value_seq #(.MAX_CYC(6), .WIDTH(2), .CYC_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .period(period),
        .val(val1), .past_val(past1), .changed(chg1), .stable(stb1), .rose(rose1), .fell(fell1),
        .cyc(cyc1), .busy(busy1), .done(done1)
`ifdef SVF_SEQ_SELFCHECK_EN
        , .obs_changed(obs1), .mismatch(mm1), .mismatch_cnt(mcnt1)
`endif
    );

    function automatic int mc(int i);
        return (i == 0) ? 11 : 6;
    endfunction

    function automatic int msk(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // value after n updates since the sequence started from v0
    function automatic int fval(int i, int n);
        int t;
        case (m_mode[i])
            0: t = n;
            1: t = 0;
            2: t = (n == 0) ? 0 : 1 + (n - 1) / (m_per[i] + 1);
            default: return (m_v0[i] + n) & msk(i);
        endcase
        return (t % 2 == 1) ? (~m_v0[i] & msk(i)) : m_v0[i];
    endfunction

    function automatic int e_val(int i);
        return fval(i, m_n[i]);
    endfunction

    function automatic int e_past(int i);
        return (m_n[i] == 0) ? m_v0[i] : fval(i, m_n[i] - 1);
    endfunction

    function automatic int e_chg(int i);
        return (m_st[i] == 1 && e_val(i) != e_past(i)) ? 1 : 0;
    endfunction

    task automatic check(string name, int act, int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_n[i] = 0; m_v0[i] = 0; m_mode[i] = 0; m_per[i] = 0; m_cyc[i] = 0;
`ifdef SVF_SEQ_SELFCHECK_EN
            m_mm[i] = 0; m_cnt[i] = 0;
`endif
        end
    endtask

    task automatic model_edge();
        int nv;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
`ifdef SVF_SEQ_SELFCHECK_EN
            begin
                int o;
                o = (i == 0) ? int'(obs0) : int'(obs1);
                m_mm[i] = 0;
                if (m_st[i] == 0 && start && !abort) m_cnt[i] = 0;
                else if (m_st[i] == 1 && o != e_chg(i)) begin
                    m_mm[i] = 1;
                    if (m_cnt[i] < 255) m_cnt[i]++;
                end
            end
`endif
            case (m_st[i])
                0: if (start && !abort) begin
                    nv = e_val(i);
                    m_v0[i] = nv; m_n[i] = 1; m_mode[i] = int'(mode); m_per[i] = int'(period);
                    m_cyc[i] = 0; m_st[i] = 1;
                end
                1: if (abort) m_st[i] = 0;
                   else begin
                       m_n[i]++;
                       if (m_cyc[i] == mc(i) - 1) m_st[i] = 2;
                       else m_cyc[i]++;
                   end
                default: m_st[i] = 0;
            endcase
        end
    endtask

    task automatic cmp_inst(int i, int a_val, int a_past, int a_chg, int a_stb, int a_rose,
                            int a_fell, int a_cyc, int a_busy, int a_done);
        int ev, ep, r;
        ev = e_val(i); ep = e_past(i); r = (m_st[i] == 1) ? 1 : 0;
        check($sformatf("d%0d.val s%0d", i, s), a_val, ev);
        check($sformatf("d%0d.past_val s%0d", i, s), a_past, ep);
        check($sformatf("d%0d.changed s%0d", i, s), a_chg, r & (ev != ep));
        check($sformatf("d%0d.stable s%0d", i, s), a_stb, r & (ev == ep));
        check($sformatf("d%0d.rose s%0d", i, s), a_rose, r & (ev & 1) & ~ep & 1);
        check($sformatf("d%0d.fell s%0d", i, s), a_fell, r & ~ev & 1 & ep);
        check($sformatf("d%0d.cyc s%0d", i, s), a_cyc, m_cyc[i]);
        check($sformatf("d%0d.busy s%0d", i, s), a_busy, r);
        check($sformatf("d%0d.done s%0d", i, s), a_done, (m_st[i] == 2) ? 1 : 0);
    endtask

    task automatic clear_stats();
        s = 0; cnt_chg0 = 0; cnt_stb0 = 0; cnt_rose0 = 0; cnt_fell0 = 0; cnt_done0 = 0;
        done_step0 = -1; chg_mask0 = 0; cnt_chg1 = 0; done_step1 = -1; trace1 = 0; rose_first0 = 0;
`ifdef SVF_SEQ_SELFCHECK_EN
        mm_pulses0 = 0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_inst(0, int'(val0), int'(past0), int'(chg0), int'(stb0), int'(rose0), int'(fell0),
                 int'(cyc0), int'(busy0), int'(done0));
        cmp_inst(1, int'(val1), int'(past1), int'(chg1), int'(stb1), int'(rose1), int'(fell1),
                 int'(cyc1), int'(busy1), int'(done1));
`ifdef SVF_SEQ_SELFCHECK_EN
        check($sformatf("d0.mismatch s%0d", s), int'(mm0), m_mm[0]);
        check($sformatf("d0.mismatch_cnt s%0d", s), int'(mcnt0), m_cnt[0]);
        check($sformatf("d1.mismatch s%0d", s), int'(mm1), m_mm[1]);
        check($sformatf("d1.mismatch_cnt s%0d", s), int'(mcnt1), m_cnt[1]);
        if (mm0) mm_pulses0++;
        obs0 = 1'(e_chg(0) ^ int'(flip_en && m_st[0] == 1 && (m_cyc[0] == 2 || m_cyc[0] == 7)));
        obs1 = 1'(e_chg(1));
`endif
        if (chg0) begin cnt_chg0++; chg_mask0 |= (1 << cyc0); end
        if (stb0) cnt_stb0++;
        if (rose0) begin cnt_rose0++; if (cyc0 == 8'd0) rose_first0 = 1'b1; end
        if (fell0) cnt_fell0++;
        if (done0) begin cnt_done0++; if (done_step0 < 0) done_step0 = s; end
        if (chg1) cnt_chg1++;
        if (busy1) trace1 |= int'(val1) << (2 * int'(cyc1));
        if (done1 && done_step1 < 0) done_step1 = s;
        s++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
    endtask

    task automatic launch(logic [1:0] m, logic [3:0] p);
        mode = m; period = p; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_idle(int budget);
        int k;
        k = 0;
        while ((m_st[0] != 0 || m_st[1] != 0) && k < budget) begin
            step();
            k++;
        end
        check("idle_within_budget", (m_st[0] == 0 && m_st[1] == 0) ? 1 : 0, 1);
    endtask

    initial begin
        model_reset();
        clear_stats();
        step();
        step();
        check("reset.val", int'(val0), 0);
        check("reset.busy", int'(busy0), 0);
        check("reset.cyc", int'(cyc0), 0);
        check("reset.done", int'(done0), 0);
        check("reset.stable", int'(stb0), 0);
        rst_n = 1'b1;

        // toggle
        do_reset(); clear_stats();
        launch(2'd0, 4'd0);
        run_until_idle(40);
        check("tog.changed_cnt", cnt_chg0, 11);
        check("tog.stable_cnt", cnt_stb0, 0);
        check("tog.rose_cnt", cnt_rose0, 6);
        check("tog.fell_cnt", cnt_fell0, 5);
        check("tog.rose_at_cyc0", int'(rose_first0), 1);
        check("tog.done_pulses", cnt_done0, 1);
        check("tog.done_step", done_step0, 11);
        check("tog.final_val", int'(val0), 0);

        // hold
        do_reset(); clear_stats();
        launch(2'd1, 4'd0);
        run_until_idle(40);
        check("hold.stable_cnt", cnt_stb0, 11);
        check("hold.changed_cnt", cnt_chg0, 0);
        check("hold.rose_fell", cnt_rose0 + cnt_fell0, 0);
        check("hold.val", int'(val0), 0);

        // pulse, period 2: changed at cyc 0,3,6,9
        do_reset(); clear_stats();
        launch(2'd2, 4'd2);
        run_until_idle(40);
        check("pulse.changed_mask", chg_mask0, 585);
        check("pulse.stable_cnt", cnt_stb0, 7);

        // increment with wrap on the 2-bit, 6-cycle instance: 1,2,3,0,1,2
        do_reset(); clear_stats();
        launch(2'd3, 4'd0);
        run_until_idle(40);
        check("inc.val_trace", trace1, 2361);
        check("inc.changed_cnt", cnt_chg1, 6);
        check("inc.done_step", done_step1, 6);

        // abort at cyc 4
        do_reset(); clear_stats();
        launch(2'd0, 4'd0);
        repeat (4) step();
        check("abort.cyc_before", int'(cyc0), 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort.busy", int'(busy0), 0);
        check("abort.val_held", int'(val0), 1);
        check("abort.cyc_held", int'(cyc0), 4);
        clear_stats();
        repeat (5) step();
        check("abort.no_done", cnt_done0, 0);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("startabort.busy", int'(busy0), 0);
        step();
        check("startabort.busy_later", int'(busy0), 0);

        // start while running is ignored
        do_reset(); clear_stats();
        launch(2'd0, 4'd0);
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart.cyc", int'(cyc0), 4);
        run_until_idle(40);
        check("restart.done_step", done_step0, 11);
        check("restart.done_pulses", cnt_done0, 1);

        // asynchronous reset at cyc 5
        do_reset(); clear_stats();
        launch(2'd0, 4'd0);
        repeat (5) step();
        check("arst.cyc_before", int'(cyc0), 5);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst.val", int'(val0), 0);
        check("arst.past_val", int'(past0), 0);
        check("arst.cyc", int'(cyc0), 0);
        check("arst.busy", int'(busy0), 0);
        check("arst.changed", int'(chg0), 0);
        step();
        rst_n = 1'b1;
        clear_stats();
        repeat (4) step();
        check("arst.no_done", cnt_done0, 0);

`ifdef SVF_SEQ_SELFCHECK_EN
        do_reset(); clear_stats();
        flip_en = 1'b1;
        launch(2'd0, 4'd0);
        run_until_idle(40);
        flip_en = 1'b0;
        check("self.mismatch_pulses", mm_pulses0, 2);
        check("self.mismatch_cnt", int'(mcnt0), 2);
        launch(2'd0, 4'd0);
        check("self.cnt_cleared", int'(mcnt0), 0);
        run_until_idle(40);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sampled_value_seq.md
Name: sampled_value_seq

Overview:
- Stimulus sequencer and reference model for sampled-value function checks ($changed, $stable, $rose, $fell).
- On start, drives a pattern on `val` for exactly MAX_CYC clock cycles.
- Each cycle it also publishes the golden value of each sampled-value function, computed from registered current and past values.
- Sits beside a DUT/assertion under test in the feature-test benches; replaces ad-hoc toggle/finish logic in each test.

Parameters:
- MAX_CYC, 11: number of RUN cycles per sequence, >=1.
- WIDTH, 1: width of `val`.
- CYC_W, 8: width of the cycle counter. Must satisfy 2**CYC_W > MAX_CYC.

Ports:
- clk  in  1  sole clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sequence. Sampled only in IDLE.
- abort  in  1  terminate sequence immediately.
- mode  in  2  0=toggle, 1=hold, 2=pulse, 3=increment. Latched at start.
- period  in  4  pulse-mode hold length. Latched at start.
- val  out  WIDTH  driven stimulus value (register).
- past_val  out  WIDTH  value of `val` one clock earlier (register).
- changed  out  1  golden $changed.
- stable  out  1  golden $stable.
- rose  out  1  golden $rose on bit 0.
- fell  out  1  golden $fell on bit 0.
- cyc  out  CYC_W  RUN-cycle index.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at sequence end.

Behaviour:
- Reset state: IDLE. val=0, past_val=0, cyc=0, busy=0, done=0, div=0, latched mode/period=0. All flags are 0.
- States: IDLE, RUN, DONE.
- next(val) by mode:
  - toggle: ~val.
  - hold: val.
  - pulse: ~val.
  - increment: val+1, modulo 2**WIDTH, wraps silently.
- IDLE:
  - start=1 and abort=0: latch mode/period, past_val<=val, val<=next(val), cyc<=0, div<=0, go to RUN.
  - start=1 and abort=1 together: abort wins; stay in IDLE.
- RUN, each cycle:
  - past_val<=val.
  - val<=next(val), except pulse mode: if div==period then val<=~val and div<=0; else val holds and div<=div+1.
  - cyc<=cyc+1.
  - If cyc==MAX_CYC-1: go to DONE instead of incrementing cyc. val/past_val still update on this transition.
- DONE: one cycle. done=1. val/past_val frozen, cyc held. Next state IDLE, done returns to 0.
- abort=1 in RUN or DONE: next state IDLE, busy=0, done not asserted. val/past_val/cyc hold their values.
- Flags are combinational from registers, gated by valid = (state==RUN):
  - changed = valid & (val!=past_val)
  - stable = valid & (val==past_val)
  - rose = valid & val[0] & ~past_val[0]
  - fell = valid & ~val[0] & past_val[0]
- Outside RUN all flags are 0.
- busy = (state==RUN), registered-state decode.
- Exactly MAX_CYC cycles show valid flags per sequence. Latency from start sample to first valid flag: 1 clock.
- start while busy or in DONE: ignored; no queuing.
- Pulse mode with period=0 is identical to toggle. With period=p, `changed` is asserted in RUN cycles 0, p+1, 2(p+1), ...
- Asynchronous reset mid-sequence: immediate return to reset state, no done pulse.

Optional Feature:
- Macro: SVF_SEQ_SELFCHECK_EN.
- When defined, adds three ports:
  - obs_changed  in  1  $changed result from the monitor under test.
  - mismatch  out  1  registered pulse.
  - mismatch_cnt  out  8  mismatch count.
- In each RUN cycle, if obs_changed!=changed, then next cycle mismatch=1 and mismatch_cnt increments, saturating at 255.
- mismatch_cnt clears on an accepted start and on reset.
- When the macro is undefined, these ports and their logic are absent, with no other behavioural difference.

Test Plan:
- Toggle run (MAX_CYC=11, WIDTH=1, mode=0, start pulse from reset):
  - changed=1 and stable=0 for all 11 RUN cycles.
  - rose/fell alternate, starting rose=1 at cyc=0.
  - done pulses once, 12 clocks after start is sampled. Final val=0.
- Hold run (mode=1): stable=1, changed=0, rose=fell=0 for 11 cycles; val stays 0.
- Pulse run (mode=2, period=2): changed=1 exactly at cyc 0, 3, 6, 9 and stable elsewhere.
- Increment with wrap (WIDTH=2, mode=3, MAX_CYC=6): val sequence 1,2,3,0,1,2 in RUN. changed=1 throughout.
- Abort and priority:
  - abort at cyc=4: busy drops next clock, no done, val holds.
  - start+abort together in IDLE: stays IDLE.
  - start during RUN: ignored.
  - rst_n low at cyc=5: all outputs 0 asynchronously.
- Self-check (SVF_SEQ_SELFCHECK_EN, toggle mode): obs_changed forced 0 at cyc 2 and 7 gives 2 mismatch pulses and mismatch_cnt=2. Next start clears the count to 0.
